universal_shift_serdes: RTL
===========================

// Module: universal_shift_serdes
// PURPOSE
//  N-bit universal shift register: hold, parallel load, logical/arithmetic
//  shifts and rotates by a variable amount, plus a start-triggered
//  serializer/deserializer transfer with a bit counter and busy/done status.
//  Used as the general shift/serial-link datapath for sequential blocks.
// PARAMETERS
//  N   8  register width, N >= 2
//  CW  4  width of amt and of the bit counter; 2**CW > N
// PORTS
//  clk    in   1     clock, rising edge
//  rst    in   1     asynchronous active-low reset
//  en     in   1     clock enable; 0 freezes all state, FSM included
//  mode   in   3     operation select (see BEHAVIOUR)
//  amt    in   CW    shift/rotate amount
//  sin_l  in   1     serial in, MSB side (fill for right shifts, deserializer input)
//  sin_r  in   1     serial in, LSB side (fill for left shift)
//  d      in   N     parallel load / serializer word
//  start  in   1     begin serial transfer (mode 111 only)
//  q      out  N     register contents
//  sout   out  1     registered serial out
//  busy   out  1     serial transfer in progress
//  done   out  1     one-cycle pulse: transfer complete
// BEHAVIOUR
//  Reset (rst=0, async): q=0, sout=0, busy=0, done=0, cnt=0, FSM=IDLE;
//   mid-transfer reset aborts the transfer, no done pulse.
//  All updates on rising clk with en=1; en=0 holds everything, done included.
//  Modes (FSM in IDLE; a = min(amt,N) for shifts, amt mod N for rotates):
//   000 hold
//   001 load: q<=d
//   010 LSR: q<={a x sin_l, q[N-1:a]}; sout<=q[a-1]
//   011 LSL: q<={q[N-1-a:0], a x sin_r}; sout<=q[N-a]
//   100 ROR by a;  101 ROL by a; sout unchanged
//   110 ASR: fill with q[N-1]; sout<=q[a-1]
//   111 serial: start=1 launches a transfer; start=0 holds
//  a=0: q and sout unchanged in every shift/rotate mode.
//  a=N: LSR/LSL give all-fill word; ASR gives all sign bits.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE, mode=111, start=1: q<=d, sout<=d[0], cnt<=0, busy<=1 -> SHIFT.
//   SHIFT each edge: q<={sin_l,q[N-1:1]}, sout<=q[1], cnt<=cnt+1;
//    on the edge with cnt==N-1: busy<=0, done<=1 -> DONE.
//   DONE: next enabled edge done<=0 -> IDLE; q holds the received word.
//  sout presents d[0]..d[N-1] in the N cycles after the start edge, LSB first.
//  q after transfer = sin_l samples, first sample at q[0] and last at q[N-1].
//  Latency: start edge to done pulse = N+1 edges; back-to-back start is
//   accepted in IDLE only.
//  While busy or in DONE, mode, start, d and amt are ignored; mode change
//   cannot corrupt a transfer.
//  busy and done are never high together.
// TESTING
//  N=8: load d=8'hA5, LSR a=3, sin_l=1 -> q=8'hF4, sout=1
//  q=8'h96: ASR a=2 -> 8'hE5; ROL a=11 (3 mod 8) -> 8'hB4; a=0 -> no change
//  Serial: d=8'h3C, start, sin_l stream 1,0,1,1,0,0,1,0 -> sout 0,0,1,1,1,1,0,0;
//   q=8'h4D; done high exactly 9 edges after start; busy high 8 cycles
//  en=0 for 3 cycles mid-transfer -> sout/cnt frozen, done delayed by 3 cycles
//  rst low at bit 4 of transfer -> q=0, busy=0, no done; a new start works
//  start or mode change while busy -> ignored, transfer data unchanged

Source files
------------

// File: rtl/universal_shift_serdes.sv
// N-bit universal shift register with a start-triggered LSB-first serializer/deserializer.
// Shifts clamp the amount to N, rotates reduce it modulo N, and en=0 freezes every register.
module universal_shift_serdes #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] amt,
  input  logic          sin_l,
  input  logic          sin_r,
  input  logic [N-1:0]  d,
  input  logic          start,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        st, st_nx;
  logic [N-1:0]  q_nx;
  logic          sout_nx, busy_nx, done_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] sa, ra;
  logic [N-1:0]  lsr_q, lsl_q, asr_q, ror_q, rol_q;
  logic          sr_bit, sl_bit;

  assign sa = (amt > CW'(N)) ? CW'(N) : amt;
  assign ra = amt % CW'(N);

  // Double-width shifts let a=N fall out naturally as an all-fill word.
  assign lsr_q  = N'({{N{sin_l}}, q} >> sa);
  assign asr_q  = N'({{N{q[N-1]}}, q} >> sa);
  assign lsl_q  = N'(({q, {N{sin_r}}} << sa) >> N);
  assign ror_q  = N'({q, q} >> ra);
  assign rol_q  = N'(({q, q} << ra) >> N);
  assign sr_bit = 1'({q, 1'b0} >> sa);
  assign sl_bit = 1'(({1'b0, q} << sa) >> N);

  always_comb begin
    st_nx   = st;
    q_nx    = q;
    sout_nx = sout;
    cnt_nx  = cnt;
    busy_nx = busy;
    done_nx = 1'b0;
    case (st)
      S_IDLE: begin
        case (mode)
          3'b001: q_nx = d;
          3'b010: if (sa != '0) begin q_nx = lsr_q; sout_nx = sr_bit; end
          3'b011: if (sa != '0) begin q_nx = lsl_q; sout_nx = sl_bit; end
          3'b100: q_nx = ror_q;
          3'b101: q_nx = rol_q;
          3'b110: if (sa != '0) begin q_nx = asr_q; sout_nx = sr_bit; end
          3'b111: if (start) begin
            q_nx    = d;
            sout_nx = d[0];
            cnt_nx  = '0;
            busy_nx = 1'b1;
            st_nx   = S_SHIFT;
          end
          default: ;
        endcase
      end
      S_SHIFT: begin
        q_nx    = {sin_l, q[N-1:1]};
        sout_nx = q[1];
        cnt_nx  = cnt + CW'(1);
        if (cnt == CW'(N-1)) begin
          busy_nx = 1'b0;
          done_nx = 1'b1;
          st_nx   = S_DONE;
        end
      end
      S_DONE:  st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= S_IDLE;
      q    <= '0;
      sout <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (en) begin
      st   <= st_nx;
      q    <= q_nx;
      sout <= sout_nx;
      cnt  <= cnt_nx;
      busy <= busy_nx;
      done <= done_nx;
    end
  end

endmodule
